// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: next-PC select codes,
// fetch-state encoding and the bubble instruction word.
package pipeline_pkg;

  localparam logic [2:0] PC_SEQ   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_J     = 3'd2;
  localparam logic [2:0] PC_JR    = 3'd3;
  localparam logic [2:0] PC_ILLOP = 3'd4;
  localparam logic [2:0] PC_XADR  = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_select.sv
// Next-PC mux: decodes PCsrc, aligns targets, and forms the
// kernel-bit-preserving sequential increment.
// Ports: pc_i, pcsrc_i, *_tgt_i in; pc_plus4_o, redirect_o, target_o out.
module if_pc_select
  import pipeline_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic [31:0] pc_i,
  input  logic [2:0]  pcsrc_i,
  input  logic [31:0] br_tgt_i,
  input  logic [31:0] j_tgt_i,
  input  logic [31:0] jr_tgt_i,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  // Bit 31 is the kernel bit; the increment never carries into it.
  assign pc_plus4_o = {pc_i[31], pc_i[30:0] + 31'd4};

  always_comb begin
    redirect_o = 1'b1;
    target_o   = pc_plus4_o;
    unique case (pcsrc_i)
      PC_BR:    target_o = align4(br_tgt_i);
      PC_J:     target_o = align4(j_tgt_i);
      PC_JR:    target_o = align4(jr_tgt_i);
      PC_ILLOP: target_o = align4(ILLOP_PC);
      PC_XADR:  target_o = align4(XADR_PC);
      default:  redirect_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, single-outstanding IM handshake,
// stall hold buffer and stale-response discard on redirect.
// Ports: CLK/Reset, PCsrc+targets, IF_Stall, IM_* bus, IF_* to IF/ID.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [2:0]  PCsrc,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] JR_Target,
  input  logic        IF_Stall,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Rdata,
  output logic [31:0] IF_instruct,
  output logic [31:0] IF_PCplus4,
  output logic        IF_Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  daddr_q, daddr_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  if_pc_select #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_pc_sel (
    .pc_i       (pc_q),
    .pcsrc_i    (PCsrc),
    .br_tgt_i   (Branch_Target),
    .j_tgt_i    (Jump_Target),
    .jr_tgt_i   (JR_Target),
    .pc_plus4_o (pc_plus4),
    .redirect_o (redirect),
    .target_o   (target)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
      daddr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    daddr_d     = daddr_q;
    IM_Req      = 1'b0;
    IM_Addr     = pc_q;
    IF_Valid    = 1'b0;
    IF_instruct = NOP_INSTR;
    IF_PCplus4  = 32'h0;
    if (!Reset) begin
      unique case (state_q)
        FETCH: begin
          IM_Req = 1'b1;
          if (redirect) begin
            pc_d   = target;
            hold_d = NOP_INSTR;
            if (!IM_Ack) begin
              // Request stays live at the old address until acked.
              state_d = DISCARD;
              daddr_d = pc_q;
            end
          end else if (IM_Ack) begin
            IF_Valid    = 1'b1;
            IF_instruct = IM_Rdata;
            IF_PCplus4  = pc_plus4;
            if (IF_Stall) begin
              hold_d  = IM_Rdata;
              state_d = HOLD;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = target;
            hold_d  = NOP_INSTR;
            state_d = FETCH;
          end else begin
            IF_Valid    = 1'b1;
            IF_instruct = hold_q;
            IF_PCplus4  = pc_plus4;
            if (!IF_Stall) begin
              pc_d    = pc_plus4;
              hold_d  = NOP_INSTR;
              state_d = FETCH;
            end
          end
        end
        DISCARD: begin
          IM_Req  = 1'b1;
          IM_Addr = daddr_q;
          if (redirect) begin
            pc_d = target;
          end
          // An ack retires the stale request even alongside a redirect.
          if (IM_Ack) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  PCsrc = 3'd0;
  logic [31:0] Branch_Target = 32'h0;
  logic [31:0] Jump_Target = 32'h0;
  logic [31:0] JR_Target = 32'h0;
  logic        IF_Stall = 1'b0;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack = 1'b0;
  logic [31:0] IM_Rdata = 32'h0;
  logic [31:0] IF_instruct;
  logic [31:0] IF_PCplus4;
  logic        IF_Valid;

  if_fetch_stage dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .PCsrc         (PCsrc),
    .Branch_Target (Branch_Target),
    .Jump_Target   (Jump_Target),
    .JR_Target     (JR_Target),
    .IF_Stall      (IF_Stall),
    .IM_Req        (IM_Req),
    .IM_Addr       (IM_Addr),
    .IM_Ack        (IM_Ack),
    .IM_Rdata      (IM_Rdata),
    .IF_instruct   (IF_instruct),
    .IF_PCplus4    (IF_PCplus4),
    .IF_Valid      (IF_Valid)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  // Reference model: program counter, a buffered word waiting for
  // the consumer, and a stale in-flight request that must be dropped.
  logic [31:0] m_pc;
  bit          m_buffered;
  logic [31:0] m_buf;
  bit          m_stale;
  logic [31:0] m_stale_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] inc4(input logic [31:0] a);
    logic [31:0] s;
    s = a + 32'd4;
    return {a[31], s[30:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000;
    m_buffered = 0;
    m_buf = 32'h0;
    m_stale = 0;
    m_stale_addr = 32'h0;
  endtask

  // One cycle: drive inputs, check combinational outputs, advance model.
  task automatic step(input logic [2:0] src, input logic stall,
                      input logic ack, input logic [31:0] br,
                      input logic [31:0] j, input logic [31:0] jr);
    bit          req, redir, got, valid;
    logic [31:0] addr, tgt, word;
    req  = !m_buffered;
    addr = m_stale ? m_stale_addr : m_pc;
    got  = req && ack;
    PCsrc = src;
    IF_Stall = stall;
    Branch_Target = br;
    Jump_Target = j;
    JR_Target = jr;
    IM_Ack = got;
    IM_Rdata = got ? mem_word(addr) : 32'hDEAD_BEEF;
    redir = (src >= 3'd1) && (src <= 3'd5);
    case (src)
      3'd1: tgt = br & ~32'd3;
      3'd2: tgt = j & ~32'd3;
      3'd3: tgt = jr & ~32'd3;
      3'd4: tgt = 32'h8000_0004;
      3'd5: tgt = 32'h8000_0008;
      default: tgt = 32'h0;
    endcase
    valid = !redir && !m_stale && (m_buffered || got);
    word = m_buffered ? m_buf : mem_word(addr);
    #1;
    check("im_req", {31'b0, IM_Req}, {31'b0, req});
    if (req) check("im_addr", IM_Addr, addr);
    check("if_valid", {31'b0, IF_Valid}, {31'b0, valid});
    check("if_instruct", IF_instruct, valid ? word : 32'h0);
    check("if_pcplus4", IF_PCplus4, valid ? inc4(m_pc) : 32'h0);
    if (redir) begin
      if (req && !got) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_pc = tgt;
      m_buffered = 0;
    end else if (m_stale) begin
      if (got) m_stale = 0;
    end else if (valid) begin
      if (!stall) begin
        m_pc = inc4(m_pc);
        m_buffered = 0;
      end else begin
        m_buffered = 1;
        m_buf = word;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic seq(input logic stall, input logic ack);
    step(3'd0, stall, ack, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_req", {31'b0, IM_Req}, 32'h0);
    check("rst_valid", {31'b0, IF_Valid}, 32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Wait with no ack, then reset mid-cycle.
    seq(0, 0);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_req", {31'b0, IM_Req}, 32'h0);
    check("midrst_valid", {31'b0, IF_Valid}, 32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
    #1;
    check("post_rst_addr", IM_Addr, 32'h8000_0000);

    // Zero-wait streaming.
    for (int i = 0; i < 4; i++) begin
      check("stream_addr", IM_Addr, 32'h8000_0000 + 32'(i) * 4);
      seq(0, 1);
    end

    // Two wait states.
    seq(0, 0);
    seq(0, 0);
    seq(0, 1);

    // Stall holds the word with no request.
    seq(1, 1);
    seq(1, 0);
    seq(1, 0);
    seq(1, 0);
    seq(0, 0);
    seq(0, 1);

    // Branch while unacked: stale ack dropped, then aligned target.
    step(3'd1, 0, 0, 32'h8000_0103, 32'h0, 32'h0);
    seq(0, 0);
    seq(0, 1);
    check("br_addr", IM_Addr, 32'h8000_0100);
    seq(0, 1);

    // Kernel bit kept across the increment wrap.
    step(3'd2, 0, 1, 32'h0, 32'h7FFF_FFFC, 32'h0);
    seq(0, 1);
    check("wrap_user", IM_Addr, 32'h0000_0000);
    step(3'd3, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFFE);
    seq(0, 1);
    check("wrap_kernel", IM_Addr, 32'h8000_0000);

    // Redirects from HOLD and DISCARD, exception vectors.
    seq(1, 1);
    step(3'd4, 1, 0, 32'h0, 32'h0, 32'h0);
    check("illop_addr", IM_Addr, 32'h8000_0004);
    step(3'd5, 0, 0, 32'h0, 32'h0, 32'h0);
    step(3'd1, 0, 0, 32'h0000_1235, 32'h0, 32'h0);
    seq(0, 1);
    check("disc_redir_addr", IM_Addr, 32'h0000_1234);
    seq(0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      step(s, ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
           $urandom, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register. It feeds IF_instruct and IF_PCplus4 into that register.
- Owns the PC register, selects the next PC (sequential, branch, jump, jr, exception vectors), and runs a single-outstanding request/ack handshake to instruction memory with arbitrary wait states.
- Holds a fetched instruction across hazard stalls and discards in-flight fetches on redirect.
- Presents a bubble (IF_Valid=0, IF_instruct=0, i.e. nop) whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
ILLOP_PC, 32'h8000_0004, target for PCsrc=ILLOP
XADR_PC, 32'h8000_0008, target for PCsrc=XADR

Ports:
CLK  in  1  clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
PCsrc  in  3  next-PC select: 0 PC+4, 1 branch, 2 jump, 3 jr, 4 ILLOP, 5 XADR; nonzero = redirect, 6/7 treated as 0
Branch_Target  in  32  branch target, from ID
Jump_Target  in  32  jump target, from ID
JR_Target  in  32  register target, from ID
IF_Stall  in  1  hazard unit: downstream will not accept this cycle
IM_Req  out  1  instruction-memory request
IM_Addr  out  32  fetch address; stable while IM_Req=1
IM_Ack  in  1  response valid; same-cycle ack (zero wait) allowed
IM_Rdata  in  32  instruction word, valid with IM_Ack
IF_instruct  out  32  instruction to IF/ID register; 0 when not valid
IF_PCplus4  out  32  PC+4 of presented instruction; 0 when not valid
IF_Valid  out  1  presented instruction is real; top uses ~IF_Valid as bubble/flush

Behaviour:
- Reset (async, any state):
  - PC=RESET_PC, state=FETCH, hold buffer empty.
  - IM_Req=0 while Reset is high.
  - Outstanding fetches are abandoned; the memory shares the same Reset.
- States:
  - FETCH: request issued. IM_Req=1, IM_Addr=PC.
  - HOLD: an instruction is buffered. IM_Req=0. IF_instruct comes from the hold register.
  - DISCARD: the in-flight request is stale. IM_Req=1 at the old address until IM_Ack, and the response is dropped.
- Acceptance is a cycle with IF_Valid=1 and IF_Stall=0.
- FETCH:
  - IM_Ack=1 and PCsrc=0: IF_Valid=1, IF_instruct=IM_Rdata, IF_PCplus4=PC+4. This path is combinational, with 0 cycles of added latency.
  - Same, and IF_Stall=0: PC<=PC+4, stay FETCH.
  - Same, and IF_Stall=1: hold_reg<=IM_Rdata, go to HOLD.
  - IM_Ack=0: IF_Valid=0, outputs 0.
- HOLD:
  - IF_Valid=1 from the hold register.
  - IF_Stall=0: PC<=PC+4, go to FETCH.
  - Otherwise stay in HOLD.
- Redirect (PCsrc nonzero, one cycle from ID) has highest priority, over IF_Stall and IM_Ack:
  - PC<=target and the hold buffer is cleared.
  - IF_Valid=0 in the redirect cycle; any same-cycle ack is dropped.
  - Next state:
    - FETCH if the request was acked this cycle or none was outstanding (HOLD).
    - DISCARD if the request is unacked.
- DISCARD:
  - On IM_Ack: drop the data, go to FETCH at the (already updated) PC.
  - A further redirect while in DISCARD overwrites PC and stays in DISCARD.
  - IF_Valid=0 throughout.
- PC arithmetic:
  - PC+4 = {PC[31], PC[30:0]+4}. The kernel bit is preserved; carry out of bit 30 is discarded.
  - All targets are loaded with bits [1:0] forced to 00.
- Exactly one outstanding request at any time. IM_Addr never changes while a request is unacked.

Decomposition:
- Shared package pipeline_pkg holds:
  - PCsrc encodings: PC_SEQ, PC_BR, PC_J, PC_JR, PC_ILLOP, PC_XADR.
  - The fetch-state enum: FETCH, HOLD, DISCARD.
  - NOP_INSTR = 32'h0.
- One sub-module is natural: if_pc_select, the combinational next-PC mux, which does PCsrc decode, alignment and kernel-bit-preserving increment.

Test Plan:
- Reset asserted mid-WAIT (IM_Req=1, no ack) -> IM_Req=0 and PC=32'h8000_0000 immediately; after release, first IM_Addr=32'h8000_0000.
- Zero-wait memory, IF_Stall=0, 4 cycles -> IM_Addr 0x80000000, 04, 08, 0C on consecutive cycles; IF_PCplus4 = addr+4; IF_Valid=1 every cycle.
- 2-wait-state memory -> IF_Valid=0 for 2 cycles, then 1 with correct word; IM_Addr stable across the wait cycles.
- Ack with IF_Stall=1 for 3 cycles -> IM_Req=0 and IF_instruct=held word for 3 cycles; PC advances only after IF_Stall drops.
- Branch redirect (PCsrc=1, Branch_Target=0x80000103) while request unacked -> next ack dropped (IF_Valid=0); next IM_Addr=0x80000100.
- PC=0x7FFFFFFC, sequential -> next PC=0x00000000 (kernel bit 0 kept). PC=0xFFFFFFFC -> next PC=0x80000000.
